// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory port.
// Round-robin on ties, programmable wait states, registered ack and read data.
module mem_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          owner_d
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       we_q;
    logic       grant_d;

    // owner_d still holds the last served requester while idle
    assign grant_d = d_req & (~i_req | ~owner_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            busy    <= 1'b0;
            owner_d <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            m_we  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        owner_d <= grant_d;
                        m_addr  <= grant_d ? d_addr : i_addr;
                        m_be    <= grant_d ? d_be : 4'hF;
                        m_wdata <= grant_d ? d_wdata : '0;
                        we_q    <= grant_d & d_we;
                        m_we    <= grant_d & d_we;
                        m_en    <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= WAIT_CNT;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        m_en  <= 1'b0;
                        state <= RESP;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!we_q) d_rdata <= m_rdata;
                        end else begin
                            i_ack <= 1'b1;
                            if (!we_q) i_rdata <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
